rx_mm2tx_cpl: RTL and testbench

- Completion builder downstream of the MWr/MRd-to-Avalon translator.
- For each decoded MRd, it captures the register read data returned on the Avalon bus.
- It formats a 3DW CplD TLP and streams it to the HIP TX Avalon-ST port (64-bit).
- For non-posted UR requests it sends a data-less Cpl with status UR.
- It pulses oFR_TX_DONE_PULSE when the TLP's last beat is accepted. The translator uses this pulse to release the decoder.

---
 rtl/rx_mm2tx_cpl.sv | 224 ++++++++++++++++++++++
 tb/tb_rx_mm2tx_cpl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_mm2tx_cpl.sv
// rtl/rx_mm2tx_cpl.sv - builds the CplD/Cpl TLP for a decoded MRd or non-posted UR and streams it on the 64-bit HIP TX port
// Optional build macro: TX_CPL_POISON_ON_TIMEOUT_EN (sets EP on a CplD whose register read timed out)
module rx_mm2tx_cpl #(
  parameter int unsigned CTR_W        = 20,
  parameter logic [63:0] TIMEOUT_DATA = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [CTR_W-1:0] iREG_PCIETIMEOUTPERIOD,
  output logic             oREG_PCIERDTIMEOUTCTR_EN,
  input  logic             iDECODE_VALID,
  input  logic             iTLP_MRD,
  input  logic             iTLP_UR,
  input  logic             iTLP_NON_POSTED,
  input  logic [15:0]      iREQ_ID,
  input  logic [7:0]       iTAG,
  input  logic [2:0]       iTC,
  input  logic [1:0]       iATTR,
  input  logic [9:0]       iLEN,
  input  logic [6:0]       iLOWER_ADDR,
  input  logic [15:0]      iCPL_ID,
  input  logic             iMM_ACK_PULSE,
  input  logic [63:0]      iMM_RD_DATA,
  output logic             oTX_ST_VALID,
  input  logic             iTX_ST_READY,
  output logic             oTX_ST_SOP,
  output logic             oTX_ST_EOP,
  output logic             oTX_ST_EMPTY,
  output logic [63:0]      oTX_ST_DATA,
  output logic             oFR_TX_DONE_PULSE
);

`ifdef TX_CPL_POISON_ON_TIMEOUT_EN
  localparam bit POISON_EN = 1'b1;
`else
  localparam bit POISON_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RD,
    S_HDR,
    S_DW2,
    S_DATA,
    S_DONE,
    S_WAIT_DEASSERT
  } state_t;

  state_t state_q, state_d;

  logic             ur_q;
  logic [9:0]       len_q;
  logic [6:0]       laddr_q;
  logic [15:0]      req_id_q;
  logic [7:0]       tag_q;
  logic [2:0]       tc_q;
  logic [1:0]       attr_q;
  logic [15:0]      cpl_id_q;
  logic [63:0]      rd_q;
  logic             tmo_q;
  logic [CTR_W-1:0] ctr_q;
  logic             strobe_q;

  logic        trig;
  logic        mrd_ok;
  logic        ack_hit;
  logic        tmo_hit;
  logic        tx_fire;
  logic        last_at_dw2;
  logic        ep;
  logic [31:0] dw0;
  logic [31:0] dw1;
  logic [31:0] dw2;

  assign trig = (iDECODE_VALID & iTLP_MRD) | (iTLP_UR & iTLP_NON_POSTED);

  // Only single-qword reads are served; anything wider or straddling a qword is answered as UR.
  assign mrd_ok = iDECODE_VALID & iTLP_MRD & ~iTLP_UR &
                  ((iLEN == 10'd1) | ((iLEN == 10'd2) & ~iLOWER_ADDR[2]));

  assign ack_hit = (state_q == S_WAIT_RD) & iMM_ACK_PULSE;
  assign tmo_hit = (state_q == S_WAIT_RD) & ~iMM_ACK_PULSE & (ctr_q == iREG_PCIETIMEOUTPERIOD);

  assign tx_fire     = oTX_ST_VALID & iTX_ST_READY;
  assign last_at_dw2 = ur_q | laddr_q[2];
  assign ep          = POISON_EN & tmo_q & ~ur_q;

  assign dw0 = {1'b0, (ur_q ? 2'b00 : 2'b10), 5'b01010, 1'b0, tc_q, 4'b0000,
                1'b0, ep, attr_q, 2'b00, (ur_q ? 10'd0 : len_q)};
  assign dw1 = {cpl_id_q, (ur_q ? 3'b001 : 3'b000), 1'b0, (ur_q ? 12'd4 : {len_q, 2'b00})};
  assign dw2 = {req_id_q, tag_q, 1'b0, (ur_q ? 7'd0 : laddr_q)};

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = mrd_ok ? S_WAIT_RD : S_HDR;
        end
      end
      S_WAIT_RD: begin
        if (ack_hit || tmo_hit) begin
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (tx_fire) begin
          state_d = S_DW2;
        end
      end
      S_DW2: begin
        if (tx_fire) begin
          state_d = last_at_dw2 ? S_DONE : S_DATA;
        end
      end
      S_DATA: begin
        if (tx_fire) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_WAIT_DEASSERT;
      end
      S_WAIT_DEASSERT: begin
        if (!trig) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    oTX_ST_VALID      = 1'b0;
    oTX_ST_SOP        = 1'b0;
    oTX_ST_EOP        = 1'b0;
    oTX_ST_EMPTY      = 1'b0;
    oTX_ST_DATA       = 64'd0;
    oFR_TX_DONE_PULSE = 1'b0;
    case (state_q)
      S_HDR: begin
        oTX_ST_VALID = 1'b1;
        oTX_ST_SOP   = 1'b1;
        oTX_ST_DATA  = {dw1, dw0};
      end
      S_DW2: begin
        oTX_ST_VALID = 1'b1;
        oTX_ST_EOP   = last_at_dw2;
        oTX_ST_EMPTY = ur_q;
        oTX_ST_DATA  = {((ur_q || !laddr_q[2]) ? 32'd0 : rd_q[63:32]), dw2};
      end
      S_DATA: begin
        oTX_ST_VALID = 1'b1;
        oTX_ST_EOP   = 1'b1;
        oTX_ST_EMPTY = (len_q == 10'd1);
        oTX_ST_DATA  = (len_q == 10'd1) ? {32'd0, rd_q[31:0]} : rd_q;
      end
      S_DONE: begin
        oFR_TX_DONE_PULSE = 1'b1;
      end
      default: begin
        oTX_ST_VALID = 1'b0;
      end
    endcase
  end

  assign oREG_PCIERDTIMEOUTCTR_EN = strobe_q;

  // Request fields are frozen on the trigger so a changing decoder cannot corrupt the TLP in flight.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      ur_q     <= 1'b0;
      len_q    <= 10'd0;
      laddr_q  <= 7'd0;
      req_id_q <= 16'd0;
      tag_q    <= 8'd0;
      tc_q     <= 3'd0;
      attr_q   <= 2'd0;
      cpl_id_q <= 16'd0;
    end else if ((state_q == S_IDLE) && trig) begin
      ur_q     <= ~mrd_ok;
      len_q    <= iLEN;
      laddr_q  <= iLOWER_ADDR;
      req_id_q <= iREQ_ID;
      tag_q    <= iTAG;
      tc_q     <= iTC;
      attr_q   <= iATTR;
      cpl_id_q <= iCPL_ID;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rd_q     <= 64'd0;
      tmo_q    <= 1'b0;
      ctr_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= tmo_hit;
      if (state_q == S_IDLE) begin
        ctr_q <= '0;
        tmo_q <= 1'b0;
      end else if (ack_hit) begin
        rd_q <= iMM_RD_DATA;
      end else if (tmo_hit) begin
        rd_q  <= TIMEOUT_DATA;
        tmo_q <= 1'b1;
      end else if (state_q == S_WAIT_RD) begin
        ctr_q <= ctr_q + CTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rx_mm2tx_cpl.sv
// tb/tb_rx_mm2tx_cpl.sv - directed bench with a TLP-level model of the completion builder
module tb_rx_mm2tx_cpl;
  localparam int CTR_W = 20;
`ifdef TX_CPL_POISON_ON_TIMEOUT_EN
  localparam bit POISON = 1'b1;
`else
  localparam bit POISON = 1'b0;
`endif
  localparam logic [63:0] RD1   = 64'h1122_3344_5566_7788;
  localparam logic [15:0] CPLID = 16'hABCD;
  localparam logic [15:0] RID   = 16'h1234;

  logic iCLK = 1'b0;
  logic iRST;
  logic [CTR_W-1:0] period;
  logic strobe;
  logic dec_valid, mrd, ur, np;
  logic [15:0] req_id, cpl_id;
  logic [7:0] tag;
  logic [2:0] tc;
  logic [1:0] attr;
  logic [9:0] len;
  logic [6:0] laddr;
  logic ack;
  logic [63:0] rd;
  logic tv, tr, sop, eop, empty, done;
  logic [63:0] tdata;

  typedef struct packed {
    logic [63:0] data;
    logic sop;
    logic eop;
    logic empty;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int tests = 0, fails = 0;
  int cyc = 0, done_cnt = 0, strobe_cnt = 0, strobe_cyc = 0;
  bit done_due = 1'b0;

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;

  rx_mm2tx_cpl #(.CTR_W(CTR_W)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iREG_PCIETIMEOUTPERIOD(period), .oREG_PCIERDTIMEOUTCTR_EN(strobe),
    .iDECODE_VALID(dec_valid), .iTLP_MRD(mrd), .iTLP_UR(ur), .iTLP_NON_POSTED(np),
    .iREQ_ID(req_id), .iTAG(tag), .iTC(tc), .iATTR(attr), .iLEN(len),
    .iLOWER_ADDR(laddr), .iCPL_ID(cpl_id),
    .iMM_ACK_PULSE(ack), .iMM_RD_DATA(rd),
    .oTX_ST_VALID(tv), .iTX_ST_READY(tr), .oTX_ST_SOP(sop), .oTX_ST_EOP(eop),
    .oTX_ST_EMPTY(empty), .oTX_ST_DATA(tdata), .oFR_TX_DONE_PULSE(done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic beat_t mk(input logic [63:0] d, input logic s, input logic e, input logic m);
    beat_t b;
    b.data = d; b.sop = s; b.eop = e; b.empty = m;
    return b;
  endfunction

  // Expected completion derived from TLP field rules.
  function automatic void push_cpl(input bit is_ur, input logic [9:0] l, input logic [6:0] a,
                                   input logic [7:0] t, input logic [2:0] c, input logic [1:0] at,
                                   input logic [63:0] data, input bit tmo);
    logic [31:0] d0, d1, d2;
    bit epb;
    epb = POISON && tmo && !is_ur;
    d0 = (is_ur ? 32'h0A00_0000 : 32'h4A00_0000) | (32'(c) << 20) | (32'(at) << 12)
       | (32'(epb) << 14) | (is_ur ? 32'd0 : 32'(l));
    d1 = (32'(CPLID) << 16) | (is_ur ? 32'h0000_2004 : 32'(l) * 4);
    d2 = (32'(RID) << 16) | (32'(t) << 8) | (is_ur ? 32'd0 : 32'(a));
    exp_q.push_back(mk({d1, d0}, 1'b1, 1'b0, 1'b0));
    if (is_ur) exp_q.push_back(mk({32'd0, d2}, 1'b0, 1'b1, 1'b1));
    else if (a[2]) exp_q.push_back(mk({data[63:32], d2}, 1'b0, 1'b1, 1'b0));
    else begin
      exp_q.push_back(mk({32'd0, d2}, 1'b0, 1'b0, 1'b0));
      if (l == 10'd1) exp_q.push_back(mk({32'd0, data[31:0]}, 1'b0, 1'b1, 1'b1));
      else exp_q.push_back(mk(data, 1'b0, 1'b1, 1'b0));
    end
  endfunction

  always @(negedge iCLK) begin
    if (!iRST) begin
      if (done_due || done) check("done_pulse", 64'(done), 64'(done_due));
      done_due = 1'b0;
      if (tv) begin
        if (exp_q.size() == 0) check("unexpected_beat", 64'(tv), 64'd0);
        else begin
          check("beat_data", tdata, exp_q[0].data);
          check("beat_sop", 64'(sop), 64'(exp_q[0].sop));
          check("beat_eop", 64'(eop), 64'(exp_q[0].eop));
          check("beat_empty", 64'(empty), 64'(exp_q[0].empty));
          if (tr) begin
            beat_t b;
            obs_q.push_back(mk(tdata, sop, eop, empty));
            done_due = exp_q[0].eop;
            b = exp_q.pop_front();
          end
        end
      end
      if (done) done_cnt++;
      if (strobe) begin
        strobe_cnt++;
        strobe_cyc = cyc;
      end
    end
  end

  task automatic start_req(input bit m, input bit u, input logic [9:0] l, input logic [6:0] a,
                           input logic [7:0] t, input logic [2:0] c, input logic [1:0] at,
                           input bit hold);
    @(posedge iCLK); #1;
    dec_valid = 1'b1; mrd = m; ur = u; np = 1'b1;
    len = l; laddr = a; tag = t; tc = c; attr = at;
    @(posedge iCLK); #1;
    if (!hold) begin
      dec_valid = 1'b0; mrd = 1'b0; ur = 1'b0;
    end
  endtask

  task automatic give_ack(input logic [63:0] d);
    @(posedge iCLK); #1;
    ack = 1'b1; rd = d;
    @(posedge iCLK); #1;
    ack = 1'b0; rd = 64'd0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 300) begin
      @(negedge iCLK); #1;
      n++;
    end
    check("done_count", 64'(done_cnt), 64'(target));
    check("exp_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge iCLK);
  endtask

  task automatic wait_sop();
    int n = 0;
    @(negedge iCLK); #1;
    while (!(tv && sop) && n < 50) begin
      @(negedge iCLK); #1;
      n++;
    end
    check("sop_seen", 64'(tv && sop), 64'd1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_valid"}, 64'(tv), 64'd0);
    check({name, "_sop_eop_empty"}, {61'd0, sop, eop, empty}, 64'd0);
    check({name, "_data"}, tdata, 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_strobe"}, 64'(strobe), 64'd0);
  endtask

  initial begin
    int base, ent;
    iRST = 1'b1; period = 20'd100; tr = 1'b1;
    dec_valid = 0; mrd = 0; ur = 0; np = 0; req_id = RID; cpl_id = CPLID;
    tag = 0; tc = 0; attr = 0; len = 0; laddr = 0; ack = 0; rd = 0;
    repeat (3) @(posedge iCLK);
    #1 check_idle_outputs("reset");
    iRST = 1'b0;

    // MRd LEN=1 addr 0x10 tag 0x2A
    start_req(1, 0, 10'd1, 7'h10, 8'h2A, 3'd0, 2'd0, 0);
    push_cpl(0, 10'd1, 7'h10, 8'h2A, 3'd0, 2'd0, RD1, 0);
    give_ack(RD1);
    wait_done(1);
    check("t1_beats", 64'(obs_q.size()), 64'd3);
    if (obs_q.size() == 3) begin
      check("t1_beat0", obs_q[0].data, 64'hABCD_0004_4A00_0001);
      check("t1_beat1", obs_q[1].data, 64'h0000_0000_1234_2A10);
      check("t1_beat2", obs_q[2].data, 64'h0000_0000_5566_7788);
      check("t1_empty2", 64'(obs_q[2].empty), 64'd1);
    end
    obs_q.delete();

    // MRd LEN=1 addr 0x14, TC=5 Attr=2 -> two beats
    start_req(1, 0, 10'd1, 7'h14, 8'h33, 3'd5, 2'd2, 0);
    push_cpl(0, 10'd1, 7'h14, 8'h33, 3'd5, 2'd2, RD1, 0);
    give_ack(RD1);
    wait_done(2);
    check("t2_beats", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() == 2) begin
      check("t2_beat0", obs_q[0].data, 64'hABCD_0004_4A50_2001);
      check("t2_beat1", obs_q[1].data, 64'h1122_3344_1234_3314);
      check("t2_eop_empty", {62'd0, obs_q[1].eop, obs_q[1].empty}, 64'd2);
    end
    obs_q.delete();

    // LEN=2 timeout with period 5
    period = 20'd5;
    base = strobe_cnt;
    push_cpl(0, 10'd2, 7'h08, 8'h44, 3'd0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    start_req(1, 0, 10'd2, 7'h08, 8'h44, 3'd0, 2'd0, 0);
    ent = cyc;
    wait_done(3);
    check("t3_strobe_cnt", 64'(strobe_cnt - base), 64'd1);
    check("t3_strobe_cyc", 64'(strobe_cyc - ent), 64'd6);
    if (obs_q.size() == 3) begin
      check("t3_beat0", obs_q[0].data, 64'hABCD_0008_4A00_0002 | (64'(POISON) << 14));
      check("t3_beat2", obs_q[2].data, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    obs_q.delete();

    // ack in the same cycle the counter reaches the period: ack wins
    base = strobe_cnt;
    start_req(1, 0, 10'd1, 7'h10, 8'h77, 3'd0, 2'd0, 0);
    repeat (4) @(posedge iCLK);
    push_cpl(0, 10'd1, 7'h10, 8'h77, 3'd0, 2'd0, 64'hCAFE_F00D_1234_5678, 0);
    give_ack(64'hCAFE_F00D_1234_5678);
    wait_done(4);
    check("t4_no_strobe", 64'(strobe_cnt - base), 64'd0);
    obs_q.delete();

    // period 0 times out on the first WAIT_RD cycle
    period = 20'd0;
    base = strobe_cnt;
    push_cpl(0, 10'd1, 7'h20, 8'h10, 3'd0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    start_req(1, 0, 10'd1, 7'h20, 8'h10, 3'd0, 2'd0, 0);
    ent = cyc;
    wait_done(5);
    check("t5_strobe_cnt", 64'(strobe_cnt - base), 64'd1);
    check("t5_strobe_cyc", 64'(strobe_cyc - ent), 64'd1);
    obs_q.delete();
    period = 20'd100;

    // non-posted UR tag 0x07
    push_cpl(1, 10'd1, 7'h55, 8'h07, 3'd0, 2'd0, 64'd0, 0);
    start_req(0, 1, 10'd1, 7'h55, 8'h07, 3'd0, 2'd0, 0);
    wait_done(6);
    check("t6_beats", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() == 2) begin
      check("t6_beat0", obs_q[0].data, 64'hABCD_2004_0A00_0000);
      check("t6_beat1", obs_q[1].data, 64'h0000_0000_1234_0700);
      check("t6_empty1", 64'(obs_q[1].empty), 64'd1);
    end
    obs_q.delete();

    // malformed MRds answered as UR
    push_cpl(1, 10'd3, 7'h10, 8'h08, 3'd0, 2'd0, 64'd0, 0);
    start_req(1, 0, 10'd3, 7'h10, 8'h08, 3'd0, 2'd0, 0);
    wait_done(7);
    push_cpl(1, 10'd2, 7'h04, 8'h09, 3'd0, 2'd0, 64'd0, 0);
    start_req(1, 0, 10'd2, 7'h04, 8'h09, 3'd0, 2'd0, 0);
    wait_done(8);
    obs_q.delete();

    // READY 1-0-0-1, stray ack while stalled, decode held past done
    start_req(1, 0, 10'd1, 7'h10, 8'h5A, 3'd0, 2'd0, 1);
    push_cpl(0, 10'd1, 7'h10, 8'h5A, 3'd0, 2'd0, RD1, 0);
    give_ack(RD1);
    wait_sop();
    @(posedge iCLK); #1;
    tr = 1'b0; ack = 1'b1; rd = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge iCLK); #1;
    ack = 1'b0; rd = 64'd0;
    @(posedge iCLK); #1;
    tr = 1'b1;
    wait_done(9);
    repeat (6) @(posedge iCLK);
    check("t8_single_tlp", 64'(obs_q.size()), 64'd3);
    if (obs_q.size() == 3) check("t8_beat1", obs_q[1].data, 64'h0000_0000_1234_5A10);
    dec_valid = 1'b0; mrd = 1'b0;
    repeat (4) @(posedge iCLK);
    check("t8_no_retrigger", 64'(done_cnt), 64'd9);
    obs_q.delete();

    // reset while the DW2 beat is stalled
    start_req(1, 0, 10'd1, 7'h10, 8'h66, 3'd0, 2'd0, 0);
    push_cpl(0, 10'd1, 7'h10, 8'h66, 3'd0, 2'd0, RD1, 0);
    give_ack(RD1);
    wait_sop();
    @(posedge iCLK); #1;
    tr = 1'b0;
    #2 iRST = 1'b1;
    #1 check_idle_outputs("midreset");
    exp_q.delete(); obs_q.delete(); done_due = 1'b0;
    @(posedge iCLK); @(posedge iCLK); #1;
    iRST = 1'b0; tr = 1'b1;
    repeat (10) @(posedge iCLK);
    check("t9_no_done", 64'(done_cnt), 64'd9);
    start_req(1, 0, 10'd1, 7'h10, 8'h2A, 3'd0, 2'd0, 0);
    push_cpl(0, 10'd1, 7'h10, 8'h2A, 3'd0, 2'd0, RD1, 0);
    give_ack(RD1);
    wait_done(10);
    if (obs_q.size() == 3) check("t9_beat0", obs_q[0].data, 64'hABCD_0004_4A00_0001);
    else check("t9_beats", 64'(obs_q.size()), 64'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
